light_pen_detect: RTL

Light-pen front end that drives the `we` input of `led_driver`. It synchronises the raw phototransistor output and tracks the one-hot row/column scan position from `scan_driver`. When the pen sees a lit dot, it latches that dot's coordinates, corrected for optical lag. On the next scan pass over that dot it issues a single-cycle `we`, so the LED RAM write lands on the correct address.

---
 rtl/light_pen_detect.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/light_pen_detect.sv
// Light-pen front end: synchronises the pen, tracks the scan position and
// issues a single-cycle LED RAM write strobe when the lag-corrected hit dot
// comes round again.
module light_pen_detect #(
   parameter int unsigned HIT_CYCLES  = 8,
   parameter int unsigned LAG_SLOTS   = 1,
   parameter int unsigned MISS_FRAMES = 4,
   parameter int unsigned ARM_FRAMES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pen_raw,
   input  logic [7:0] led_row,
   input  logic [7:0] led_col,
   output logic       we,
   output logic [2:0] hit_row,
   output logic [2:0] hit_col,
   output logic       pen_present,
   output logic       busy
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned POS_W  = 6;
   localparam int unsigned HIST_D = 4;
   localparam int unsigned FRM_W  = 4;
   localparam int unsigned SEEN_W = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // One-hot decode: {exactly_one_bit_set, index_of_set_bit}
   function automatic logic [3:0] dec_onehot(input logic [7:0] v);
      logic [2:0] idx;
      logic [3:0] ones;
      idx  = '0;
      ones = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            idx  = 3'(i);
            ones = ones + 4'd1;
         end
      end
      return {(ones == 4'd1), idx};
   endfunction

   state_t             state_q, state_d;
   logic               pen_meta_q, pen_s_q;
   logic [15:0]        scan_q;
   logic [POS_W-1:0]   pos_q;
   logic               pos_valid_q;
   logic [POS_W-1:0]   hist_q [HIST_D];
   logic [POS_W-1:0]   hist_d [HIST_D];
   logic [SEEN_W-1:0]  seen_q, seen_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cnt_full_q, cnt_full_d;
   logic [FRM_W-1:0]   age_q, age_d;
   logic [FRM_W-1:0]   miss_q, miss_d;
   logic [2:0]         hit_row_q, hit_row_d;
   logic [2:0]         hit_col_q, hit_col_d;
   logic               present_q, present_d;
   logic               we_q, we_d;
   logic               busy_q, busy_d;

   logic [3:0]         row_dec_c, col_dec_c;
   logic               pos_valid_c;
   logic [POS_W-1:0]   pos_c;
   logic               slot_start_c;
   logic               frame_c;
   logic [POS_W-1:0]   target_c;
   logic               qual_c;
   logic               lag_ok_c;
   logic               match_c;
   logic               latch_c;

   // Scan position decode and slot / frame boundary detection
   always_comb begin
      row_dec_c    = dec_onehot(led_row);
      col_dec_c    = dec_onehot(led_col);
      pos_valid_c  = row_dec_c[3] & col_dec_c[3];
      pos_c        = {row_dec_c[2:0], col_dec_c[2:0]};
      slot_start_c = ({led_row, led_col} != scan_q);
      frame_c      = slot_start_c && pos_valid_c && (pos_c == '0);
      target_c     = hist_q[2'(LAG_SLOTS)];
      qual_c       = (cnt_q == CNT_W'(HIT_CYCLES)) && !cnt_full_q;
      lag_ok_c     = (seen_q >= SEEN_W'(LAG_SLOTS));
      match_c      = pos_valid_q && (pos_q == {hit_row_q, hit_col_q});
   end

   // FSM next state: latch in IDLE, wait for the target, strobe one cycle
   always_comb begin
      state_d = state_q;
      latch_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (qual_c && lag_ok_c) begin
               latch_c = 1'b1;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (match_c) begin
               state_d = S_WRITE;
            end else if (frame_c && (age_q == FRM_W'(ARM_FRAMES - 1))) begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next state: history, integrator, frame counters, outputs
   always_comb begin
      for (int i = 0; i < HIST_D; i++) begin
         hist_d[i] = hist_q[i];
      end
      seen_d = seen_q;
      if (slot_start_c && pos_valid_c) begin
         hist_d[0] = pos_c;
         for (int i = 1; i < HIST_D; i++) begin
            hist_d[i] = hist_q[i-1];
         end
         if (seen_q != '1) begin
            seen_d = seen_q + SEEN_W'(1);
         end
      end

      cnt_full_d = (cnt_q == CNT_W'(HIT_CYCLES));
      cnt_d      = cnt_q;
      if (slot_start_c || !pen_s_q) begin
         cnt_d = '0;
      end else if (pos_valid_c && (cnt_q < CNT_W'(HIT_CYCLES))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      age_d  = age_q;
      miss_d = miss_q;
      if (latch_c) begin
         age_d  = '0;
         miss_d = '0;
      end else if (frame_c) begin
         if (age_q != '1) begin
            age_d = age_q + FRM_W'(1);
         end
         if (miss_q != '1) begin
            miss_d = miss_q + FRM_W'(1);
         end
      end

      present_d = present_q;
      if (latch_c) begin
         present_d = 1'b1;
      end else if (miss_d >= FRM_W'(MISS_FRAMES)) begin
         present_d = 1'b0;
      end

      hit_row_d = latch_c ? target_c[5:3] : hit_row_q;
      hit_col_d = latch_c ? target_c[2:0] : hit_col_q;
      we_d      = (state_d == S_WRITE);
      busy_d    = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pen_meta_q  <= 1'b0;
         pen_s_q     <= 1'b0;
         scan_q      <= '0;
         pos_q       <= '0;
         pos_valid_q <= 1'b0;
         for (int i = 0; i < HIST_D; i++) begin
            hist_q[i] <= '0;
         end
         seen_q      <= '0;
         cnt_q       <= '0;
         cnt_full_q  <= 1'b0;
         age_q       <= '0;
         miss_q      <= '0;
         hit_row_q   <= '0;
         hit_col_q   <= '0;
         present_q   <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pen_meta_q  <= pen_raw;
         pen_s_q     <= pen_meta_q;
         scan_q      <= {led_row, led_col};
         pos_q       <= pos_c;
         pos_valid_q <= pos_valid_c;
         for (int i = 0; i < HIST_D; i++) begin
            hist_q[i] <= hist_d[i];
         end
         seen_q      <= seen_d;
         cnt_q       <= cnt_d;
         cnt_full_q  <= cnt_full_d;
         age_q       <= age_d;
         miss_q      <= miss_d;
         hit_row_q   <= hit_row_d;
         hit_col_q   <= hit_col_d;
         present_q   <= present_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
      end
   end

   assign we          = we_q;
   assign hit_row     = hit_row_q;
   assign hit_col     = hit_col_q;
   assign pen_present = present_q;
   assign busy        = busy_q;

endmodule
